// File: rtl/fpcvt_pkg.sv
// Shared definitions for the linear-to-float converter and its rounding stage.
package fpcvt_pkg;

  localparam int DEF_EXP_W = 3;
  localparam int DEF_SIG_W = 4;

  localparam logic [DEF_EXP_W-1:0] EXP_MAX = '1;
  localparam logic [DEF_SIG_W-1:0] SIG_MAX = '1;

  typedef struct packed {
    logic                 sign;
    logic [DEF_EXP_W-1:0] exp;
    logic [DEF_SIG_W-1:0] sig;
  } fp_word_t;

endpackage

// File: rtl/fpcvt_round_core.sv
// Combinational round-half-away-from-zero on magnitude, carry into exponent,
// clamp to maximum magnitude when the exponent is already at its top value.
module fpcvt_round_core #(
  parameter int EXP_W = 3,
  parameter int SIG_W = 4
) (
  input  logic [EXP_W-1:0] t_exp,
  input  logic [SIG_W-1:0] t_sig,
  input  logic             round,
  output logic [EXP_W-1:0] r_exp,
  output logic [SIG_W-1:0] r_sig,
  output logic             sat
);

  logic [SIG_W:0] sum;

  always_comb begin
    sum   = {1'b0, t_sig} + {{SIG_W{1'b0}}, round};
    r_exp = t_exp;
    r_sig = sum[SIG_W-1:0];
    sat   = 1'b0;
    if (sum[SIG_W]) begin
      if (t_exp != '1) begin
        // Significand overflowed to 2^SIG_W; renormalise by one position.
        r_exp = t_exp + 1'b1;
        r_sig = sum[SIG_W:1];
      end else begin
        r_exp = '1;
        r_sig = '1;
        sat   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpcvt_round.sv
// Two-stage rounding pipeline with valid/ready on both sides.
// Define FPCVT_ROUND_STATS_EN to add the saturating sat_count port.
module fpcvt_round
  import fpcvt_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int SIG_W = DEF_SIG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [SIG_W-1:0] in_sig,
  input  logic             in_round,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [EXP_W-1:0] out_exp,
  output logic [SIG_W-1:0] out_sig,
  output logic             out_sat
`ifdef FPCVT_ROUND_STATS_EN
  ,
  output logic [15:0]      sat_count
`endif
);

  logic             s1_valid;
  logic             s1_sign;
  logic [EXP_W-1:0] s1_exp;
  logic [SIG_W-1:0] s1_sig;
  logic             s1_round;

  logic             s1_adv;
  logic             s2_adv;

  logic [EXP_W-1:0] r_exp;
  logic [SIG_W-1:0] r_sig;
  logic             r_sat;

  // out_valid doubles as the stage-2 valid flag.
  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = s2_adv;
  assign in_ready = !s1_valid || s1_adv;

  fpcvt_round_core #(
    .EXP_W (EXP_W),
    .SIG_W (SIG_W)
  ) u_core (
    .t_exp (s1_exp),
    .t_sig (s1_sig),
    .round (s1_round),
    .r_exp (r_exp),
    .r_sig (r_sig),
    .sat   (r_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_exp    <= '0;
      s1_sig    <= '0;
      s1_round  <= 1'b0;
      out_valid <= 1'b0;
      out_sign  <= 1'b0;
      out_exp   <= '0;
      out_sig   <= '0;
      out_sat   <= 1'b0;
    end else begin
      // s1 may refill while s2 is stalled as long as s1 itself was empty.
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_sign  <= in_sign;
          s1_exp   <= in_exp;
          s1_sig   <= in_sig;
          s1_round <= in_round;
        end
      end
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_sign <= s1_sign;
          out_exp  <= r_exp;
          out_sig  <= r_sig;
          out_sat  <= r_sat;
        end
      end
    end
  end

`ifdef FPCVT_ROUND_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_count <= '0;
    end else if (out_valid && out_ready && out_sat && (sat_count != '1)) begin
      sat_count <= sat_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fpcvt_round.sv
// Self-checking bench for fpcvt_round: directed vectors plus a queue-based reference model.
module tb_fpcvt_round;
  import fpcvt_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       in_sign = 1'b0;
  logic [2:0] in_exp = '0;
  logic [3:0] in_sig = '0;
  logic       in_round = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_sign;
  logic [2:0] out_exp;
  logic [3:0] out_sig;
  logic       out_sat;
`ifdef FPCVT_ROUND_STATS_EN
  logic [15:0] sat_count;
`endif

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    fp_word_t w;
    logic     sat;
  } exp_t;

  exp_t q[$];
  int   model_sat = 0;

  fpcvt_round #(.EXP_W(3), .SIG_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_sig    (in_sig),
    .in_round  (in_round),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_exp   (out_exp),
    .out_sig   (out_sig),
    .out_sat   (out_sat)
`ifdef FPCVT_ROUND_STATS_EN
    ,
    .sat_count (sat_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Value-level rule: magnitude = sig + round; fits -> keep, overflow -> renormalise or clamp.
  function automatic exp_t model(input logic s, input logic [2:0] e, input logic [3:0] g,
                                 input logic r);
    exp_t m;
    int   mag;
    mag = int'(g) + int'(r);
    m.w.sign = s;
    m.sat    = 1'b0;
    if (mag < 16) begin
      m.w.exp = e;
      m.w.sig = 4'(mag);
    end else if (int'(e) < 7) begin
      m.w.exp = 3'(int'(e) + 1);
      m.w.sig = 4'(mag / 2);
    end else begin
      m.w.exp = 3'd7;
      m.w.sig = 4'd15;
      m.sat   = 1'b1;
    end
    return m;
  endfunction

  logic       held = 1'b0;
  logic       p_sign;
  logic [2:0] p_exp;
  logic [3:0] p_sig;
  logic       p_sat;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      held = 1'b0;
      model_sat = 0;
    end else begin
      if (held) begin
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_data", int'({out_sign, out_exp, out_sig, out_sat}),
            int'({p_sign, p_exp, p_sig, p_sat}));
      end
`ifdef FPCVT_ROUND_STATS_EN
      chk("sat_count", int'(sat_count), model_sat);
`endif
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          exp_t m;
          m = q.pop_front();
          chk("out_sign", int'(out_sign), int'(m.w.sign));
          chk("out_exp", int'(out_exp), int'(m.w.exp));
          chk("out_sig", int'(out_sig), int'(m.w.sig));
          chk("out_sat", int'(out_sat), int'(m.sat));
          if (m.sat && model_sat < 65535) model_sat++;
        end
      end
      if (in_valid && in_ready) q.push_back(model(in_sign, in_exp, in_sig, in_round));
      held   = out_valid && !out_ready;
      p_sign = out_sign;
      p_exp  = out_exp;
      p_sig  = out_sig;
      p_sat  = out_sat;
    end
  end

  task automatic push(input logic s, input logic [2:0] e, input logic [3:0] g, input logic r);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = e;
    in_sig   = g;
    in_round = r;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("push_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Push with empty pipe and out_ready high; checks 2-cycle latency and literal result.
  task automatic one(input string name, input logic s, input logic [2:0] e,
                     input logic [3:0] g, input logic r,
                     input int xs, input int xe, input int xg, input int xsat);
    push(s, e, g, r);
    @(negedge clk);
    chk({name, "_lat1"}, int'(out_valid), 0);
    @(negedge clk);
    chk({name, "_valid"}, int'(out_valid), 1);
    chk({name, "_sign"}, int'(out_sign), xs);
    chk({name, "_exp"}, int'(out_exp), xe);
    chk({name, "_sig"}, int'(out_sig), xg);
    chk({name, "_sat"}, int'(out_sat), xsat);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((q.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit done;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_word", int'({out_sign, out_exp, out_sig, out_sat}), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", int'(in_ready), 1);
    chk("post_rst_out_valid", int'(out_valid), 0);
    @(posedge clk);
    #1;

    one("roundup", 1'b0, 3'd3, 4'b1010, 1'b1, 0, 3, 4'b1011, 0);
    one("carry", 1'b1, 3'd3, 4'b1111, 1'b1, 1, 4, 4'b1000, 0);
    one("sat", 1'b0, 3'd7, 4'b1111, 1'b1, 0, 7, 4'b1111, 1);
    one("exp0_carry", 1'b0, 3'd0, 4'b1111, 1'b1, 0, 1, 4'b1000, 0);
    one("noround", 1'b1, 3'd5, 4'b1001, 1'b0, 1, 5, 4'b1001, 0);
    one("exp7_noover", 1'b0, 3'd7, 4'b1110, 1'b1, 0, 7, 4'b1111, 0);
`ifdef FPCVT_ROUND_STATS_EN
    @(negedge clk);
    chk("sat_count_after_one", int'(sat_count), 1);
    @(posedge clk);
    #1;
`endif

    // Backpressure: A and B fill both stages, then in_ready must drop.
    out_ready = 1'b0;
    push(1'b0, 3'd2, 4'b1100, 1'b1);
    push(1'b1, 3'd6, 4'b1111, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_in_ready_low", int'(in_ready), 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    fork
      push(1'b0, 3'd7, 4'b1111, 1'b1);
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("bp_no_gap", int'(out_valid), 1);
        end
      end
    join
    drain();

    // Reset with two words in flight; neither may emerge.
    out_ready = 1'b0;
    push(1'b0, 3'd1, 4'b0101, 1'b1);
    push(1'b1, 3'd4, 4'b0011, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst_no_old", int'(out_valid), 0);
    end
    @(posedge clk);
    #1;

    // Random stream with random downstream stalls.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          push(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
               4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();

`ifdef FPCVT_ROUND_STATS_EN
    // Long saturating run to exercise the counter clamp.
    for (int i = 0; i < 65540; i++) push(1'b0, 3'd7, 4'b1111, 1'b1);
    drain();
    @(negedge clk);
    chk("sat_count_clamp", int'(sat_count), 16'hFFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fpcvt_round.md
Name: fpcvt_round

Overview:
- Pipelined rounding stage directly downstream of the linear-to-float converter.
- Takes the truncated exponent/significand pair, the sign, and the first discarded magnitude bit (round bit). Emits the final rounded, saturated sign/exponent/significand word.
- Two-stage pipeline with valid/ready handshake on both sides; full throughput, one word per cycle.

Parameters:
- EXP_W, 3, exponent width.
- SIG_W, 4, significand width (MSB is the explicit leading bit when exponent > 0).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  stage can accept a word this cycle.
- in_sign  in  1  sign bit, passed through unchanged.
- in_exp  in  EXP_W  truncated exponent from converter.
- in_sig  in  SIG_W  truncated significand from converter.
- in_round  in  1  first bit below significand LSB; 0 when in_exp == 0.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts word.
- out_sign  out  1  sign.
- out_exp  out  EXP_W  rounded exponent.
- out_sig  out  SIG_W  rounded significand.
- out_sat  out  1  word was clamped to maximum magnitude.
- sat_count  out  16  saturation counter; present only with FPCVT_ROUND_STATS_EN.

Behaviour:
- Reset:
  - rst high at any edge clears s1_valid, s2_valid, out_valid, out_sign, out_exp, out_sig, out_sat (and sat_count) to 0.
  - Words in flight are dropped. in_ready reads 1 in the cycle after reset deasserts.
- Handshake:
  - A transfer occurs when valid && ready on a given side.
  - Valid, once asserted, holds its data stable until accepted; bench-checked on the output side.
  - in_ready = !s1_valid || s1_adv.
- Stage advance:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = s2_adv, moving s1 into s2 when s1_valid.
  - out_* are the s2 registers.
- Stage 1: registers {sign, exp, sig, round}; computes sum = {1'b0, sig} + round, SIG_W+1 bits wide.
- Stage 2 packing, evaluated in this order:
  - If sum[SIG_W] == 0: exp unchanged, sig = sum[SIG_W-1:0], sat = 0.
  - Else if exp < 2^EXP_W-1: exp + 1, sig = 1 followed by SIG_W-1 zeros (i.e. sum >> 1), sat = 0.
  - Else (exp at max): exp = all ones, sig = all ones, sat = 1.
- Exponent 0 with round = 1 and sig = 1111 follows the same overflow rule: 0 -> exp 1, sig 1000.
- Latency: exactly 2 cycles from input acceptance to out_valid when out_ready is held high.
- Backpressure:
  - With out_ready low, up to 2 words are buffered (s1 + s2), then in_ready drops.
  - No word is lost or duplicated; order is preserved.
- Simultaneous accept-in and accept-out when full: both occur in the same cycle; occupancy is unchanged.
- Sign never participates in arithmetic; negative and positive inputs round identically (round half away from zero on magnitude).

Optional Feature:
- Macro: FPCVT_ROUND_STATS_EN.
- Defined:
  - Adds the sat_count port.
  - sat_count increments by 1 on every output transfer with out_sat = 1.
  - Saturates at 16'hFFFF, no wrap. Cleared by rst.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package fpcvt_pkg:
  - EXP_W/SIG_W default constants, EXP_MAX = all ones, SIG_MAX = all ones.
  - Packed struct fp_word_t {sign, exp, sig}, reused by the converter and top level.
- One combinational sub-module, fpcvt_round_core: input {exp, sig, round}; output {exp, sig, sat}. Instantiated in stage 2.
- Pipeline and handshake logic stay in fpcvt_round.

Test Plan:
- Plain round-up, out_ready = 1: exp=3, sig=1010, round=1, sign=0 -> 2 cycles later exp=3, sig=1011, sat=0.
- Carry into exponent: exp=3, sig=1111, round=1, sign=1 -> exp=4, sig=1000, sign=1, sat=0.
- Saturation: exp=7, sig=1111, round=1 -> exp=7, sig=1111, sat=1; with FPCVT_ROUND_STATS_EN, sat_count 0 -> 1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles while offering words A, B, C back-to-back.
  - in_ready drops after A and B are accepted.
  - Releasing out_ready yields A, B, C in order with no gaps once flowing.
- Reset mid-operation: 2 words in flight, rst pulsed 1 cycle -> out_valid=0 next cycle; old words never appear; in_ready=1.
- Stream: 100 random {exp, sig, round} words with random out_ready -> outputs match a reference model bit-exact and in order; sat_count equals the model's saturation count, clamped at 16'hFFFF in a forced long run.
